// File: rtl/write_ptr_ctrl.sv
// Write-side pointer and full-flag logic for the async sample FIFO.
// Exports a Gray write pointer and derives full/almost-full/level from the synchronised read pointer.
module write_ptr_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int AF_THRESH = 2**ADDR_SIZE - 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic [ADDR_SIZE:0]   rd_gray_i,
    input  logic                 clr_ovf_i,
    output logic                 wr_en_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic [ADDR_SIZE:0]   ptr_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [ADDR_SIZE:0]   level_o,
    output logic                 overflow_o
);

    localparam logic [ADDR_SIZE:0] LP_AF = (ADDR_SIZE+1)'(AF_THRESH);

    logic [ADDR_SIZE:0] r_bin;
    logic [ADDR_SIZE:0] r_gray;
    logic [ADDR_SIZE:0] r_rq1;
    logic [ADDR_SIZE:0] r_rq2;
    logic               r_full;
    logic               r_ovf;

    logic               w_accept;
    logic [ADDR_SIZE:0] w_bin_n;
    logic [ADDR_SIZE:0] w_gray_n;
    logic [ADDR_SIZE:0] w_full_tgt;
    logic [ADDR_SIZE:0] w_rq2_bin;
    logic [ADDR_SIZE:0] w_level;

    assign w_accept = inc_i & ~r_full;
    assign w_bin_n  = r_bin + {{ADDR_SIZE{1'b0}}, w_accept};
    assign w_gray_n = w_bin_n ^ (w_bin_n >> 1);

    // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
    assign w_full_tgt = {~r_rq2[ADDR_SIZE:ADDR_SIZE-1], r_rq2[ADDR_SIZE-2:0]};

    always_comb begin
        w_rq2_bin = '0;
        for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
            w_rq2_bin[i] = ^(r_rq2 >> i);
        end
    end

    assign w_level = r_bin - w_rq2_bin;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_rq1  <= '0;
            r_rq2  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_bin  <= w_bin_n;
            r_gray <= w_gray_n;
            r_rq1  <= rd_gray_i;
            r_rq2  <= r_rq1;
            r_full <= (w_gray_n == w_full_tgt);
            if (inc_i & r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign wr_en_o       = w_accept;
    assign addr_o        = r_bin[ADDR_SIZE-1:0];
    assign ptr_o         = r_gray;
    assign full_o        = r_full;
    assign level_o       = w_level;
    assign almost_full_o = (w_level >= LP_AF);
    assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Bench for write_ptr_ctrl (depth 8): occupancy model checked every cycle, plus directed literal checks.
module tb_write_ptr_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       inc_i = 1'b0;
    logic [3:0] rd_gray_i = '0;
    logic       clr_ovf_i = 1'b0;
    logic       wr_en_o;
    logic [2:0] addr_o;
    logic [3:0] ptr_o;
    logic       full_o;
    logic       almost_full_o;
    logic [3:0] level_o;
    logic       overflow_o;

    int n_cmp = 0;
    int n_err = 0;
    int rd_bin = 0;

    write_ptr_ctrl #(.ADDR_SIZE(3), .AF_THRESH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (inc_i),
        .rd_gray_i    (rd_gray_i),
        .clr_ovf_i    (clr_ovf_i),
        .wr_en_o      (wr_en_o),
        .addr_o       (addr_o),
        .ptr_o        (ptr_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .level_o      (level_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: writes accepted so far and the read position seen two edges ago, as plain counts mod 16.
    int m_wptr = 0, m_rq1 = 0, m_rq2 = 0;
    bit m_full = 0, m_ovf = 0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_wptr = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0; m_ovf = 0;
        end else begin
            if (inc_i && m_full) m_ovf = 1;
            else if (clr_ovf_i) m_ovf = 0;
            if (inc_i && !m_full) m_wptr = (m_wptr + 1) % 16;
            m_full = (((m_wptr - m_rq2) & 15) == 8);
            m_rq2 = m_rq1;
            m_rq1 = rd_bin;
        end
    end

    always @(negedge clk_i) begin
        int lvl;
        #3;
        lvl = (m_wptr - m_rq2) & 15;
        chk("wr_en", int'(wr_en_o), int'(inc_i && !m_full));
        chk("addr", int'(addr_o), m_wptr % 8);
        chk("ptr", int'(ptr_o), m_wptr ^ (m_wptr >> 1));
        chk("full", int'(full_o), int'(m_full));
        chk("level", int'(level_o), lvl);
        chk("almost_full", int'(almost_full_o), int'(lvl >= 4));
        chk("overflow", int'(overflow_o), int'(m_ovf));
    end

    task automatic drive(input bit inc, input int rb, input bit clr);
        @(negedge clk_i);
        inc_i = inc;
        rd_bin = rb;
        rd_gray_i = 4'(rb ^ (rb >> 1));
        clr_ovf_i = clr;
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        inc_i = 1'b0; rd_bin = 0; rd_gray_i = '0; clr_ovf_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_full", int'(full_o), 0);
        chk("rst_ptr", int'(ptr_o), 0);
        rst_i = 1'b0;

        // Reset mid-operation with inc_i held high
        for (int k = 0; k < 3; k++) drive(1, 0, 0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_addr", int'(addr_o), 0);
        chk("midrst_ptr", int'(ptr_o), 0);
        chk("midrst_level", int'(level_o), 0);
        chk("midrst_wr_en", int'(wr_en_o), 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("first_addr", int'(addr_o), 0);
        chk("first_wr_en", int'(wr_en_o), 1);
        after_edge();
        chk("second_addr", int'(addr_o), 1);

        // Almost-full threshold, then fill to full
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0);
            #1;
            chk("fill_addr", int'(addr_o), k);
            if (k == 3) begin
                chk("af_lvl3", int'(level_o), 3);
                chk("af_off", int'(almost_full_o), 0);
            end
            if (k == 4) begin
                chk("af_lvl4", int'(level_o), 4);
                chk("af_on", int'(almost_full_o), 1);
            end
        end
        after_edge();
        chk("fill_full", int'(full_o), 1);
        chk("fill_level", int'(level_o), 8);
        chk("fill_ptr", int'(ptr_o), 4'b1100);

        // Overflow behaviour while full
        drive(1, 0, 0);
        #1;
        chk("ovf_wr_en", int'(wr_en_o), 0);
        chk("ovf_addr", int'(addr_o), 0);
        after_edge();
        chk("ovf_set", int'(overflow_o), 1);
        drive(0, 0, 1);
        after_edge();
        chk("ovf_clr", int'(overflow_o), 0);
        drive(1, 0, 1);
        after_edge();
        chk("ovf_set_wins", int'(overflow_o), 1);
        drive(0, 0, 1);
        after_edge();

        // Full release after read pointer moves to 2
        drive(0, 2, 0);
        after_edge();
        chk("rel_e1_full", int'(full_o), 1);
        drive(0, 2, 0);
        after_edge();
        chk("rel_e2_full", int'(full_o), 1);
        drive(0, 2, 0);
        after_edge();
        chk("rel_e3_full", int'(full_o), 0);
        chk("rel_level", int'(level_o), 6);
        chk("rel_af", int'(almost_full_o), 1);

        // Wrap with the read pointer tracking the writer
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1, k, 0);
            after_edge();
            chk("wrap_full", int'(full_o), 0);
            if (k == 14) chk("wrap_ptr15", int'(ptr_o), 4'b1000);
        end
        chk("wrap_ptr0", int'(ptr_o), 4'b0000);
        chk("wrap_addr0", int'(addr_o), 0);
        repeat (4) drive(0, 0, 0);
        @(negedge clk_i);
        #5;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
